// File: rtl/dft_arb_pkg.sv
// Shared encodings and widths for the DFT capture-port commit arbiter.
package dft_arb_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dft_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping past the top chain.
module dft_rr_pick #(
    parameter int p_sc_nbr = 16,
    parameter int p_idx_w  = 4
) (
    input  logic [p_sc_nbr-1:0] req,
    input  logic [p_idx_w-1:0]  ptr,
    output logic                gnt_valid,
    output logic [p_idx_w-1:0]  gnt_idx
);

    localparam int               L_POS_W = $clog2(2 * p_sc_nbr);
    localparam logic [p_idx_w:0] L_N     = (p_idx_w + 1)'(p_sc_nbr);

    logic [2*p_sc_nbr-1:0] w_dbl;
    logic [p_sc_nbr-1:0]   w_rot;
    logic [L_POS_W-1:0]    w_pos;
    logic [p_idx_w-1:0]    w_off;
    logic [p_idx_w:0]      w_sum;

    // Doubling the request vector turns the wrap-around search into a plain shift.
    assign w_dbl = {req, req};

    always_comb begin
        // NOTE: every combinational output gets a default before the loop so no latch is inferred.
        w_rot = '0;
        w_pos = '0;
        for (int i = 0; i < p_sc_nbr; i++) begin
            w_pos    = L_POS_W'(ptr) + L_POS_W'(i);
            w_rot[i] = w_dbl[w_pos];
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        w_off     = '0;
        for (int i = p_sc_nbr - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                gnt_valid = 1'b1;
                w_off     = p_idx_w'(i);
            end
        end
    end

    always_comb begin
        w_sum   = {1'b0, ptr} + {1'b0, w_off};
        gnt_idx = (w_sum >= L_N) ? p_idx_w'(w_sum - L_N) : w_sum[p_idx_w-1:0];
    end

endmodule

// File: rtl/dft_commit_arbiter.sv
// Arbitrates scan-chain commits onto the single register-file capture write port,
// with per-chain acknowledge, sticky done bits and a completed-write counter.
module dft_commit_arbiter
    import dft_arb_pkg::*;
#(
    parameter int p_sc_nbr = 16,
    parameter int p_idx_w  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [p_sc_nbr-1:0]          dft_op_commit,
    input  logic [WORD_W*p_sc_nbr-1:0]   dft_output_data,
    output logic [p_sc_nbr-1:0]          dft_commit_ack,
    output logic                         rf_wr_en,
    output logic [p_idx_w-1:0]           rf_wr_idx,
    output logic [WORD_W-1:0]            rf_wr_data,
    input  logic                         rf_wr_rdy,
    input  logic                         clr_done,
    output logic [p_sc_nbr-1:0]          done_mask,
    output logic [CNT_W-1:0]             commit_cnt,
    output logic                         busy
);

    localparam logic [p_idx_w-1:0] L_LAST = p_idx_w'(p_sc_nbr - 1);

    arb_state_t            r_state;
    logic [p_idx_w-1:0]    r_ptr;
    logic [p_sc_nbr-1:0]   r_ack;
    logic                  r_wr_en;
    logic [p_idx_w-1:0]    r_wr_idx;
    logic [WORD_W-1:0]     r_wr_data;
    logic [p_sc_nbr-1:0]   r_done;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;

    logic                  w_gnt_valid;
    logic [p_idx_w-1:0]    w_gnt_idx;
    logic [WORD_W-1:0]     w_gnt_data;
    logic [p_sc_nbr-1:0]   w_idx_hot;
    logic                  w_req_cur;
    logic                  w_xfer;
    logic [p_idx_w-1:0]    w_ptr_next;
    logic [p_sc_nbr-1:0]   w_done_next;

    dft_rr_pick #(
        .p_sc_nbr (p_sc_nbr),
        .p_idx_w  (p_idx_w)
    ) u_pick (
        .req       (dft_op_commit),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    always_comb begin
        w_gnt_data = '0;
        w_idx_hot  = '0;
        for (int i = 0; i < p_sc_nbr; i++) begin
            if (w_gnt_idx == p_idx_w'(i)) begin
                w_gnt_data = dft_output_data[i*WORD_W +: WORD_W];
            end
            w_idx_hot[i] = (r_wr_idx == p_idx_w'(i));
        end
    end

    assign w_req_cur  = |(dft_op_commit & w_idx_hot);
    assign w_xfer     = (r_state == WRITE) && rf_wr_rdy;
    assign w_ptr_next = (r_wr_idx == L_LAST) ? '0 : r_wr_idx + p_idx_w'(1);

    // A set on the clearing edge survives for the chain being written.
    assign w_done_next = (clr_done ? '0 : r_done) | (w_xfer ? w_idx_hot : '0);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_ack     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
            r_done    <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= w_done_next;
            case (r_state)
                IDLE: begin
                    if (en && w_gnt_valid) begin
                        r_wr_idx  <= w_gnt_idx;
                        r_wr_data <= w_gnt_data;
                        r_wr_en   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (rf_wr_rdy) begin
                        r_wr_en <= 1'b0;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_ack   <= w_idx_hot;
                        r_ptr   <= w_ptr_next;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    // Chain must see its ack before dropping the request; en is not consulted here.
                    if (!w_req_cur) begin
                        r_ack   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ack   <= '0;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dft_commit_ack = r_ack;
    assign rf_wr_en       = r_wr_en;
    assign rf_wr_idx      = r_wr_idx;
    assign rf_wr_data     = r_wr_data;
    assign done_mask      = r_done;
    assign commit_cnt     = r_cnt;
    assign busy           = r_busy;

endmodule

// File: tb/tb_dft_commit_arbiter.sv
// Scoreboard bench for dft_commit_arbiter: expected writes are queued by the stimulus
// and checked by an independent monitor whenever a write transfers.
module tb_dft_commit_arbiter;

    localparam int N  = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic [N-1:0]    dft_op_commit;
    logic [32*N-1:0] dft_output_data;
    logic [N-1:0]    dft_commit_ack;
    logic            rf_wr_en;
    logic [IW-1:0]   rf_wr_idx;
    logic [31:0]     rf_wr_data;
    logic            rf_wr_rdy;
    logic            clr_done;
    logic [N-1:0]    done_mask;
    logic [15:0]     commit_cnt;
    logic            busy;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    wr_t m_e;
    int  n_cmp = 0;
    int  n_err = 0;
    int  order[6] = '{5, 15, 0, 5, 15, 0};

    dft_commit_arbiter #(.p_sc_nbr(N), .p_idx_w(IW)) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .dft_op_commit   (dft_op_commit),
        .dft_output_data (dft_output_data),
        .dft_commit_ack  (dft_commit_ack),
        .rf_wr_en        (rf_wr_en),
        .rf_wr_idx       (rf_wr_idx),
        .rf_wr_data      (rf_wr_data),
        .rf_wr_rdy       (rf_wr_rdy),
        .clr_done        (clr_done),
        .done_mask       (done_mask),
        .commit_cnt      (commit_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [31:0] v);
        dft_output_data[ch*32 +: 32] = v;
    endtask

    task automatic push(input int ch, input logic [31:0] v);
        wr_t e;
        e.idx  = IW'(ch);
        e.data = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int max_cyc);
        for (int c = 0; c < max_cyc && dft_commit_ack == '0; c++) tick();
    endtask

    // Full commit with rdy held high: grant, transfer, ack, release.
    task automatic run_commit(input int ch, input logic [31:0] v);
        set_data(ch, v);
        push(ch, v);
        dft_op_commit[ch] = 1'b1;
        tick();
        tick();
        check("commit_ack_hi", 32'(dft_commit_ack), 32'(1) << ch);
        dft_op_commit[ch] = 1'b0;
        tick();
        check("commit_ack_lo", 32'(dft_commit_ack), 32'h0);
    endtask

    always @(negedge clk) begin
        if (reset && rf_wr_en && rf_wr_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_unexpected: got idx %0d data 0x%08h, expected no write", rf_wr_idx, rf_wr_data);
            end else begin
                m_e = exp_q.pop_front();
                check("wr_idx", 32'(rf_wr_idx), 32'(m_e.idx));
                check("wr_data", rf_wr_data, m_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        en              = 1'b0;
        dft_op_commit   = '0;
        dft_output_data = '0;
        rf_wr_rdy       = 1'b0;
        clr_done        = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ack", 32'(dft_commit_ack), 32'h0);
        check("rst_wr_en", 32'(rf_wr_en), 32'h0);
        check("rst_wr_idx", 32'(rf_wr_idx), 32'h0);
        check("rst_wr_data", rf_wr_data, 32'h0);
        check("rst_done", 32'(done_mask), 32'h0);
        check("rst_cnt", 32'(commit_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        en        = 1'b1;
        rf_wr_rdy = 1'b1;
        tick();

        // Single request on chain 3
        set_data(3, 32'hA5A5_0003);
        push(3, 32'hA5A5_0003);
        dft_op_commit[3] = 1'b1;
        tick();
        check("s1_wr_en", 32'(rf_wr_en), 32'h1);
        check("s1_wr_idx", 32'(rf_wr_idx), 32'h3);
        check("s1_busy", 32'(busy), 32'h1);
        check("s1_ack_early", 32'(dft_commit_ack), 32'h0);
        tick();
        check("s1_ack", 32'(dft_commit_ack), 32'h0008);
        check("s1_done", 32'(done_mask), 32'h0008);
        check("s1_cnt", 32'(commit_cnt), 32'h1);
        check("s1_wr_en_lo", 32'(rf_wr_en), 32'h0);
        dft_op_commit[3] = 1'b0;
        tick();
        check("s1_ack_drop", 32'(dft_commit_ack), 32'h0);
        check("s1_busy_lo", 32'(busy), 32'h0);

        // Round robin among chains 0, 5, 15 starting from ptr 4
        set_data(0, 32'hC0DE_0000);
        set_data(5, 32'hC0DE_0005);
        set_data(15, 32'hC0DE_000F);
        for (int k = 0; k < 6; k++) push(order[k], 32'hC0DE_0000 | 32'(order[k]));
        dft_op_commit[0]  = 1'b1;
        dft_op_commit[5]  = 1'b1;
        dft_op_commit[15] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_ack(20);
            check("rr_ack", 32'(dft_commit_ack), 32'(1) << order[k]);
            dft_op_commit[order[k]] = 1'b0;
            tick();
            if (k < 5) dft_op_commit[order[k]] = 1'b1;
        end
        dft_op_commit = '0;
        tick();
        check("rr_cnt", 32'(commit_cnt), 32'd7);
        check("rr_done", 32'(done_mask), 32'h8029);

        // Backpressure on chain 9, data change and request drop during stall
        rf_wr_rdy = 1'b0;
        set_data(9, 32'h1111_0009);
        push(9, 32'h1111_0009);
        dft_op_commit[9] = 1'b1;
        tick();
        check("bp_wr_en", 32'(rf_wr_en), 32'h1);
        set_data(9, 32'hDEAD_BEEF);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("bp_hold_en", 32'(rf_wr_en), 32'h1);
            check("bp_hold_idx", 32'(rf_wr_idx), 32'h9);
            check("bp_hold_data", rf_wr_data, 32'h1111_0009);
            if (i == 3) dft_op_commit[9] = 1'b0;
        end
        rf_wr_rdy = 1'b1;
        tick();
        check("bp_ack", 32'(dft_commit_ack), 32'h0200);
        check("bp_wr_en_lo", 32'(rf_wr_en), 32'h0);
        tick();
        check("bp_ack_1cyc", 32'(dft_commit_ack), 32'h0);
        check("bp_busy_lo", 32'(busy), 32'h0);
        check("bp_cnt", 32'(commit_cnt), 32'd8);

        // Enable gating on chain 2
        en = 1'b0;
        set_data(2, 32'h2222_0002);
        dft_op_commit[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_busy", 32'(busy), 32'h0);
            check("en_wr_en", 32'(rf_wr_en), 32'h0);
        end
        en = 1'b1;
        push(2, 32'h2222_0002);
        tick();
        check("en_grant", 32'(rf_wr_en), 32'h1);
        en = 1'b0;
        tick();
        check("en_ack", 32'(dft_commit_ack), 32'h0004);
        check("en_busy_hi", 32'(busy), 32'h1);
        dft_op_commit[2] = 1'b0;
        tick();
        check("en_ack_lo", 32'(dft_commit_ack), 32'h0);
        check("en_busy_lo", 32'(busy), 32'h0);
        en = 1'b1;

        // Sticky done mask with clear colliding with a set
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        check("clr_done", 32'(done_mask), 32'h0);
        run_commit(1, 32'h3333_0001);
        run_commit(2, 32'h3333_0002);
        check("sticky_mask", 32'(done_mask), 32'h0006);
        rf_wr_rdy = 1'b0;
        set_data(1, 32'h3333_1001);
        push(1, 32'h3333_1001);
        dft_op_commit[1] = 1'b1;
        tick();
        check("clr_grant_idx", 32'(rf_wr_idx), 32'h1);
        rf_wr_rdy = 1'b1;
        clr_done  = 1'b1;
        tick();
        clr_done = 1'b0;
        check("clr_set_wins", 32'(done_mask), 32'h0002);
        check("clr_ack", 32'(dft_commit_ack), 32'h0002);
        dft_op_commit[1] = 1'b0;
        tick();
        check("clr_cnt", 32'(commit_cnt), 32'd12);

        // Async reset during ACK of chain 7
        set_data(7, 32'h7777_0007);
        push(7, 32'h7777_0007);
        dft_op_commit[7] = 1'b1;
        tick();
        tick();
        check("ar_ack_hi", 32'(dft_commit_ack), 32'h0080);
        #1 reset = 1'b0;
        #1;
        check("ar_ack", 32'(dft_commit_ack), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_done", 32'(done_mask), 32'h0);
        check("ar_cnt", 32'(commit_cnt), 32'h0);
        #1 reset = 1'b1;
        push(7, 32'h7777_0007);
        tick();
        check("ar_regrant", 32'(rf_wr_en), 32'h1);
        check("ar_regrant_idx", 32'(rf_wr_idx), 32'h7);
        tick();
        check("ar_ack2", 32'(dft_commit_ack), 32'h0080);
        check("ar_cnt2", 32'(commit_cnt), 32'h1);
        check("ar_done2", 32'(done_mask), 32'h0080);
        dft_op_commit[7] = 1'b0;
        tick();
        check("ar_ack2_lo", 32'(dft_commit_ack), 32'h0);

        tick();
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
